// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. Two WIDTH-bit operands plus a carry-in are accepted
// over a valid/ready handshake and added LSB-first, one bit per clock, through
// a single full-adder cell and a carry flip-flop. The sum and carry-out are
// returned over a second valid/ready handshake. Latency from acceptance to
// out_valid is WIDTH clocks. The minimum issue interval is WIDTH+2 clocks.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   a, b, cin are valid
//   in_ready   out  block can accept operands (IDLE)
//   a          in   augend  [WIDTH-1:0]
//   b          in   addend  [WIDTH-1:0]
//   cin        in   carry-in
//   out_valid  out  sum/cout are valid (DONE)
//   out_ready  in   consumer takes the result
//   sum        out  (a + b + cin) mod 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8  // legal range 1..32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Bit counter is clog2(WIDTH) wide, but never narrower than one bit.
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic [CW-1:0]    cnt_q;

   logic             s_d;
   logic             carry_d;
   logic [WIDTH-1:0] sum_d;

   // Single full-adder cell on the current LSBs and the stored carry.
   always_comb begin
      s_d     = a_q[0] ^ b_q[0] ^ carry_q;
      carry_d = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
   end

   // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 of the
   // result has travelled down to sum[0]. A one-bit sum is just the new bit.
   generate
      if (WIDTH == 1) begin : g_sum_w1
         assign sum_d = s_d;
      end else begin : g_sum_wn
         assign sum_d = {s_d, sum_q[WIDTH-1:1]};
      end
   endgenerate

   // NOTE: every register here is sequential state, so it is assigned with <=
   //       only; blocking assignments would let later statements see new values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are reset as well, because sum and cout
         //       are visible on the ports and must read zero after reset.
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               sum_q   <= sum_d;
               carry_q <= carry_d;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  cout_q  <= carry_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Result is held until the consumer takes it. in_ready only
               // rises in the following cycle, so DONE never accepts directly.
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Handshake flags are decoded from the state register alone, so there is
   // no combinational path from any input to any output.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule
